// File: rtl/rom_load_sequencer.sv
// Purpose: owns the shared program memory port; routes HPS download bytes in, then serves CPU reads.
// Latency: download byte -> mem_we 1 cycle; cpu_rd -> cpu_valid 3 cycles.
// Backpressure: none; one write or read per cycle, reads outside RUN are dropped.
//
// Ports:
//   clk_sys, reset                       : single clock, synchronous active-high reset
//   dn_download/dn_wr/dn_addr/dn_data    : HPS download bus (level, strobe, address, byte)
//   cpu_rd/cpu_addr -> cpu_data/cpu_valid: pipelined CPU read port
//   cpu_reset_hold                       : holds the CPU in reset outside RUN
//   mem_addr/mem_din/mem_we <- mem_dout  : registered memory port, 1-cycle read latency
//   load_count/load_sum/load_overflow    : status of the last or current download
module rom_load_sequencer #(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] ROM_LAST      = 16'hBFFF,
  parameter int                SETTLE_CYCLES = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  output logic              cpu_reset_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic [ADDR_W:0]   load_count,
  output logic [7:0]        load_sum,
  output logic              load_overflow
);

  localparam int                CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_ok, wr_oob, rd_ok, clr_status;
  logic             rd_p1, rd_p2;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-cycle decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SETTLE: begin
        // A new download wins over the settle timer expiring.
        if (dn_download)       state_d = LOAD;
        else if (cnt_q == '0)  state_d = RUN;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      RUN: begin
        if (dn_download) state_d = LOAD;
      end
      LOAD: begin
        if (!dn_download) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = CNT_INIT;
      end
    endcase

    // Decoded on state_q, so a strobe on the cycle dn_download falls still lands.
    wr_ok      = (state_q == LOAD) && dn_wr && (dn_addr <= ROM_LAST);
    wr_oob     = (state_q == LOAD) && dn_wr && (dn_addr >  ROM_LAST);
    // A read issued on the cycle RUN is left would be cancelled anyway; drop it here.
    rd_ok      = (state_q == RUN) && (state_d == RUN) && cpu_rd;
    clr_status = (state_q != LOAD) && (state_d == LOAD);
  end

  // Registered outputs and read pipeline
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_reset_hold <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      rd_p1          <= 1'b0;
      rd_p2          <= 1'b0;
      cpu_valid      <= 1'b0;
      cpu_data       <= '0;
      load_count     <= '0;
      load_sum       <= '0;
      load_overflow  <= 1'b0;
    end else begin
      // Registered from next state so the hold tracks transitions without extra lag.
      cpu_reset_hold <= (state_d != RUN);

      mem_we <= wr_ok;
      if (wr_ok) begin
        mem_addr <= dn_addr;
        mem_din  <= dn_data;
      end else if (rd_ok) begin
        mem_addr <= cpu_addr;
      end

      // rd_p1: address on the memory; rd_p2: data on mem_dout. Leaving RUN flushes both.
      rd_p1     <= rd_ok;
      rd_p2     <= rd_p1 && (state_d == RUN);
      cpu_valid <= rd_p2 && (state_d == RUN);
      if (rd_p2) cpu_data <= mem_dout;

      if (clr_status) begin
        load_count    <= '0;
        load_sum      <= '0;
        load_overflow <= 1'b0;
      end else begin
        if (wr_ok) begin
          if (load_count != COUNT_MAX) load_count <= load_count + (ADDR_W+1)'(1);
          load_sum <= load_sum + dn_data;
        end
        if (wr_oob) load_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Purpose: directed bench for rom_load_sequencer with a write/read scoreboard.
// Latency: checks 1-cycle write and 3-cycle read timing against the cycle counter.
// Backpressure: n/a; the bench drives one transaction per cycle.
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dn_download, dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        cpu_rd;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_valid, cpu_reset_hold;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [16:0] load_count;
  logic [7:0]  load_sum;
  logic        load_overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_exp_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] cyc;
  } rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];

  logic [7:0] mem [0:65535];

  rom_load_sequencer #(
    .ADDR_W       (16),
    .ROM_LAST     (16'hBFFF),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .dn_download   (dn_download),
    .dn_wr         (dn_wr),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .cpu_rd        (cpu_rd),
    .cpu_addr      (cpu_addr),
    .cpu_data      (cpu_data),
    .cpu_valid     (cpu_valid),
    .cpu_reset_hold(cpu_reset_hold),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_we        (mem_we),
    .mem_dout      (mem_dout),
    .load_count    (load_count),
    .load_sum      (load_sum),
    .load_overflow (load_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Synchronous memory, 1-cycle read latency.
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Monitor: every mem_we / cpu_valid must match the head of its queue, on the expected cycle.
  always @(negedge clk_sys) begin
    if (mem_we) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h din=%h cyc=%0d (no write expected)", mem_addr, mem_din, cyc);
      end else begin
        wr_exp_t e;
        e = wq.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data || cyc !== int'(e.cyc)) begin
          failures++;
          $display("FAIL write got addr=%h din=%h cyc=%0d expected addr=%h din=%h cyc=%0d",
                   mem_addr, mem_din, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (cpu_valid) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read data=%h cyc=%0d (no read expected)", cpu_data, cyc);
      end else begin
        rd_exp_t r;
        r = rq.pop_front();
        if (cpu_data !== r.data || cyc !== int'(r.cyc)) begin
          failures++;
          $display("FAIL read got data=%h cyc=%0d expected data=%h cyc=%0d",
                   cpu_data, cyc, r.data, r.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic dn_byte(input logic [15:0] a, input logic [7:0] d);
    wr_exp_t e;
    dn_wr   = 1'b1;
    dn_addr = a;
    dn_data = d;
    if (a <= 16'hBFFF) begin
      e.addr = a;
      e.data = d;
      e.cyc  = 32'(cyc + 1);
      wq.push_back(e);
    end
    tick();
    dn_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] d);
    rd_exp_t r;
    cpu_rd   = 1'b1;
    cpu_addr = a;
    r.data   = d;
    r.cyc    = 32'(cyc + 3);
    rq.push_back(r);
    tick();
  endtask

  // Counts edges until cpu_reset_hold is seen low; bounded so a stuck hold still ends the run.
  task automatic wait_hold_low(output int n);
    n = 0;
    while (cpu_reset_hold && n < 50) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_rd = 1'b0; cpu_addr = '0;
    repeat (3) tick();

    // Reset state
    check("rst_hold",     32'(cpu_reset_hold), 32'd1);
    check("rst_mem_we",   32'(mem_we),         32'd0);
    check("rst_mem_addr", 32'(mem_addr),       32'd0);
    check("rst_mem_din",  32'(mem_din),        32'd0);
    check("rst_valid",    32'(cpu_valid),      32'd0);
    check("rst_data",     32'(cpu_data),       32'd0);
    check("rst_count",    32'(load_count),     32'd0);
    check("rst_sum",      32'(load_sum),       32'd0);
    check("rst_ovf",      32'(load_overflow),  32'd0);

    // Release: hold high exactly 4 cycles
    reset = 1'b0;
    wait_hold_low(n);
    check("release_hold_cycles", 32'(n), 32'd4);
    check("release_count", 32'(load_count), 32'd0);

    // Download 0x11,0x22,0x33 to 0..2; last byte on the cycle dn_download falls
    dn_download = 1'b1;
    tick();
    check("dl_hold_rise", 32'(cpu_reset_hold), 32'd1);
    dn_byte(16'h0000, 8'h11);
    dn_byte(16'h0001, 8'h22);
    dn_download = 1'b0;
    dn_byte(16'h0002, 8'h33);
    wait_hold_low(n);
    check("dl_hold_fall_cycles", 32'(n + 1), 32'd5);
    check("dl_count", 32'(load_count),    32'd3);
    check("dl_sum",   32'(load_sum),      32'h66);
    check("dl_ovf",   32'(load_overflow), 32'd0);

    // Back-to-back reads in RUN
    cpu_read(16'h0001, 8'h22);
    cpu_read(16'h0002, 8'h33);
    cpu_read(16'h0000, 8'h11);
    cpu_rd = 1'b0;
    repeat (5) tick();

    // Read cancelled by a download starting the next cycle
    cpu_rd = 1'b1; cpu_addr = 16'h0001;
    tick();
    cpu_rd = 1'b0;
    dn_download = 1'b1;
    tick();
    check("cancel_hold",  32'(cpu_reset_hold), 32'd1);
    check("cancel_count", 32'(load_count),     32'd0);
    check("cancel_sum",   32'(load_sum),       32'd0);
    repeat (4) tick();

    // Out-of-range byte, then boundary and in-range bytes
    dn_byte(16'hC000, 8'hAA);
    check("oob_ovf",   32'(load_overflow), 32'd1);
    check("oob_count", 32'(load_count),    32'd0);
    check("oob_we",    32'(mem_we),        32'd0);
    dn_byte(16'hBFFF, 8'h01);
    dn_byte(16'h0010, 8'h05);
    check("mix_count", 32'(load_count), 32'd2);
    check("mix_sum",   32'(load_sum),   32'h06);
    dn_download = 1'b0;
    tick();
    wait_hold_low(n);
    check("ovf_sticky", 32'(load_overflow), 32'd1);
    dn_download = 1'b1;
    tick();
    check("ovf_cleared", 32'(load_overflow), 32'd0);

    // Reset in the middle of a download, with a strobe on the reset cycle
    dn_byte(16'h0020, 8'h01);
    check("pre_rst_count", 32'(load_count), 32'd1);
    reset = 1'b1; dn_wr = 1'b1; dn_addr = 16'h0021; dn_data = 8'h77;
    tick();
    check("midrst_we",    32'(mem_we),         32'd0);
    check("midrst_count", 32'(load_count),     32'd0);
    check("midrst_sum",   32'(load_sum),       32'd0);
    check("midrst_hold",  32'(cpu_reset_hold), 32'd1);
    reset = 1'b0; dn_wr = 1'b0; dn_download = 1'b0;
    wait_hold_low(n);
    check("midrst_settle_cycles", 32'(n), 32'd4);

    // 256 bytes of 0xFF
    dn_download = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) dn_byte(16'(i), 8'hFF);
    dn_download = 1'b0;
    tick();
    wait_hold_low(n);
    check("ff_hold_fell", 32'(cpu_reset_hold), 32'd0);
    check("ff_count",     32'(load_count),     32'd256);
    check("ff_sum",       32'(load_sum),       32'h00);

    repeat (3) tick();
    check("wr_queue_drained", 32'(wq.size()), 32'd0);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
